hamming_encoder_stream: RTL
===========================

HAMMING_ENCODER_STREAM -- requirements
Module: hamming_encoder_stream

Interface
REQ-001 SHALL have parameter CNT_W, default 16: the width of the emitted-codeword counter.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the upstream nibble is valid.
REQ-005 SHALL have port in_data, input, 4 bits: the data nibble d[3:0].
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept a nibble.
REQ-007 SHALL have port out_valid, output, 1 bit: the head codeword is valid.
REQ-008 SHALL have port out_codeword, output, CW_W bits: the head codeword; CW_W is 7, or 8 when HAMMING_SECDED_EN is defined.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts the codeword.
REQ-010 SHALL have port cw_count, output, CNT_W bits: the number of codewords emitted, modulo 2^CNT_W.

Function
REQ-011 SHALL encode each nibble to Hamming(7,4) with codeword positions 1..7 mapped to bits [0]..[6]:
- data bits: c[2]=d0, c[4]=d1, c[5]=d2, c[6]=d3
- parity bits: c[0]=d0^d1^d3, c[1]=d0^d2^d3, c[3]=d1^d2^d3
REQ-012 SHALL accept an input only on an input handshake, i.e. a rising edge with in_valid=1 and in_ready=1.
REQ-013 SHALL emit a codeword only on an output handshake, i.e. a rising edge with out_valid=1 and out_ready=1.
REQ-014 SHALL buffer encoded codewords in a 2-entry FIFO and deliver them strictly in order.
REQ-015 SHALL make a nibble accepted at edge N visible on out_codeword with out_valid=1 after edge N when the FIFO was empty; latency is 1 cycle.
REQ-016 SHALL drive in_ready=1 iff the FIFO occupancy is below 2, derived from registered state with no combinational path from out_ready.
REQ-017 SHALL keep in_ready=0 when the FIFO is full, even if a pop occurs in the same cycle; in_ready SHALL rise the cycle after that pop.
REQ-018 SHALL, when a push and a pop occur on the same edge at occupancy 1, leave occupancy at 1 with the new codeword at the head.
REQ-019 SHALL hold out_codeword stable while out_valid=1 and out_ready=0.
REQ-020 SHALL drive out_valid=0 when the FIFO is empty; out_codeword SHALL then read 0.
REQ-021 SHALL increment cw_count by 1 per output handshake, wrapping from all-ones to 0.
REQ-022 SHALL ignore in_data while no input handshake occurs.

Reset
REQ-023 SHALL, while rst_n=0, immediately force out_valid=0, out_codeword=0, cw_count=0, FIFO empty and in_ready=0.
REQ-024 SHALL raise in_ready on the first clk edge after rst_n deasserts.
REQ-025 SHALL discard buffered codewords when reset is asserted mid-operation and leave no partial state.

Configuration
REQ-026 SHALL, when macro HAMMING_SECDED_EN is defined, set CW_W=8 with c[7]=XOR of c[6:0] (overall parity), giving SECDED.
REQ-027 SHALL, without HAMMING_SECDED_EN, set CW_W=7 and produce no overall parity logic.

Structure
REQ-028 SHALL take the following from a shared package hamming_pkg, also usable by the decoder side:
- the CW_W constant
- the data-position constants (2, 4, 5, 6)
- the parity-position constants (0, 1, 3)
REQ-029 SHALL place the pure-combinational encoder in sub-module hamming_enc_core, instantiated once ahead of the FIFO.

Verification
REQ-030 SHALL check: in_data=4'b1011 pushed into an empty block -> next cycle out_valid=1, out_codeword=7'h55 (SECDED: 8'h55).
REQ-031 SHALL check the encodings:
- 4'h0 -> 7'h00
- 4'hF -> 7'h7F (SECDED 8'hFF)
- 4'h1 -> 7'h07 (SECDED 8'h87)
REQ-032 SHALL check: out_ready=0 while pushing 4'h1 then 4'h2 ->
- in_ready=0 after the second push
- a third nibble is not accepted
- after out_ready=1, codewords are emitted in order 7'h07 then 7'h19, and in_ready=1 the cycle after the first pop
REQ-033 SHALL check: in_valid=1 and out_ready=1 held for 20 cycles -> one codeword per cycle after the first, and cw_count=19 at the end.
REQ-034 SHALL check: rst_n pulsed low with 2 entries buffered -> out_valid=0, cw_count=0 asynchronously, and no stale codeword after release.
REQ-035 SHALL check: with CNT_W=4, 17 handshakes -> cw_count wraps to 1.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) constants for encoder and decoder.
// Build with HAMMING_SECDED_EN defined to add the overall-parity bit (SECDED, 8-bit codewords).
package hamming_pkg;

`ifdef HAMMING_SECDED_EN
   localparam int CW_W = 8;
`else
   localparam int CW_W = 7;
`endif

   // Codeword bit index = Hamming position - 1
   localparam int D0_POS = 2;
   localparam int D1_POS = 4;
   localparam int D2_POS = 5;
   localparam int D3_POS = 6;

   localparam int P0_POS = 0;
   localparam int P1_POS = 1;
   localparam int P3_POS = 3;

   typedef logic [CW_W-1:0] cw_t;

endpackage

// File: rtl/hamming_enc_core.sv
// Pure combinational Hamming(7,4) encoder; with HAMMING_SECDED_EN it also
// appends bit 7 as the XOR of bits [6:0].
module hamming_enc_core
   import hamming_pkg::*;
(
   input  logic [3:0]      data,
   output logic [CW_W-1:0] codeword
);

   logic [6:0] base;

   always_comb begin
      base         = '0;
      base[D0_POS] = data[0];
      base[D1_POS] = data[1];
      base[D2_POS] = data[2];
      base[D3_POS] = data[3];
      base[P0_POS] = data[0] ^ data[1] ^ data[3];
      base[P1_POS] = data[0] ^ data[2] ^ data[3];
      base[P3_POS] = data[1] ^ data[2] ^ data[3];
   end

`ifdef HAMMING_SECDED_EN
   assign codeword = {^base, base};
`else
   assign codeword = base;
`endif

endmodule

// File: rtl/hamming_encoder_stream.sv
// Streaming Hamming encoder: valid/ready nibbles in, codewords out through a
// 2-entry FIFO. Codeword width follows HAMMING_SECDED_EN (see hamming_pkg).
module hamming_encoder_stream
   import hamming_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [3:0]       in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [CW_W-1:0]  out_codeword,
   input  logic             out_ready,
   output logic [CNT_W-1:0] cw_count
);

   cw_t        enc_cw;
   cw_t        slot0, slot1;
   logic [1:0] occ, occ_nxt;
   logic       push, pop;

   hamming_enc_core u_enc (
      .data     (in_data),
      .codeword (enc_cw)
   );

   assign push         = in_valid & in_ready;
   assign pop          = out_valid & out_ready;
   assign out_valid    = (occ != 2'd0);
   assign out_codeword = slot0;

   always_comb begin
      occ_nxt = occ;
      case ({push, pop})
         2'b10:   occ_nxt = occ + 2'd1;
         2'b01:   occ_nxt = occ - 2'd1;
         default: occ_nxt = occ;
      endcase
   end

   // in_ready is a register of the next occupancy, so out_ready never reaches
   // it combinationally; slot1 is cleared on every drain so slot0 reads 0 when empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ      <= 2'd0;
         in_ready <= 1'b0;
         slot0    <= '0;
         slot1    <= '0;
         cw_count <= '0;
      end else begin
         occ      <= occ_nxt;
         in_ready <= (occ_nxt != 2'd2);
         if (pop)
            cw_count <= cw_count + 1'b1;
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) slot0 <= enc_cw;
               else             slot1 <= enc_cw;
            end
            2'b01: begin
               slot0 <= slot1;
               slot1 <= '0;
            end
            2'b11: slot0 <= enc_cw;
            default: ;
         endcase
      end
   end

endmodule
